// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto one read/write master port.
// Optional watchdog abort is built when ARB_TIMEOUT_EN is defined.
module mem_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int GW            = $clog2(NUM_REQ)
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_read_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_write_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data,
    output logic [NUM_REQ-1:0]            req_read_done,
    output logic [DATA_WIDTH-1:0]         req_read_data,
    output logic [NUM_REQ-1:0]            req_write_done,
    output logic                          m_read_req,
    output logic [ADDR_WIDTH-1:0]         m_read_addr,
    input  logic [DATA_WIDTH-1:0]         m_read_data,
    input  logic                          m_read_done,
    output logic                          m_write_req,
    output logic [ADDR_WIDTH-1:0]         m_write_addr,
    output logic [DATA_WIDTH-1:0]         m_write_data,
    input  logic                          m_write_done,
    output logic                          grant_valid,
    output logic [GW-1:0]                 grant_idx,
    output logic                          timeout_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_RD = 2'd1;
    localparam logic [1:0] BUSY_WR = 2'd2;

    logic [1:0]            state;
    logic [GW-1:0]         rr_ptr;
    logic                  found;
    logic [GW-1:0]         win_idx;
    logic [GW-1:0]         cand_idx;
    int                    cand;
    logic [ADDR_WIDTH-1:0] sel_raddr;
    logic [ADDR_WIDTH-1:0] sel_waddr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  cur_done;
    logic                  expire;
    logic                  finish;
    logic [NUM_REQ-1:0]    grant_onehot;
    logic [GW-1:0]         next_ptr;

    // First requester at or after rr_ptr (wrapping) wins.
    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ)
                cand = cand - NUM_REQ;
            cand_idx = GW'(cand);
            if (!found && (req_read[cand_idx] || req_write[cand_idx])) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_comb begin
        sel_raddr = '0;
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == win_idx) begin
                sel_raddr = req_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_waddr = req_write_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cur_done = ((state == BUSY_RD) && m_read_done) ||
                      ((state == BUSY_WR) && m_write_done);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            to_cnt <= '0;
        else if (state == IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + CW'(1);
    end

    // A done landing on the expiry cycle wins and suppresses the error.
    assign expire = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CYCLES - 1)) && !cur_done;
`else
    // Watchdog compiled out: the expression is constant false.
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    assign finish       = cur_done || expire;
    assign timeout_err  = expire;
    assign grant_onehot = NUM_REQ'(1) << grant_idx;
    assign next_ptr     = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + GW'(1);

    assign req_read_done  = ((state == BUSY_RD) && (m_read_done || expire)) ? grant_onehot : '0;
    assign req_write_done = ((state == BUSY_WR) && (m_write_done || expire)) ? grant_onehot : '0;
    assign req_read_data  = expire ? '0 : m_read_data;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
            m_read_req   <= 1'b0;
            m_write_req  <= 1'b0;
            m_read_addr  <= '0;
            m_write_addr <= '0;
            m_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_idx   <= win_idx;
                        grant_valid <= 1'b1;
                        if (req_read[win_idx]) begin
                            state       <= BUSY_RD;
                            m_read_req  <= 1'b1;
                            m_read_addr <= sel_raddr;
                        end else begin
                            state        <= BUSY_WR;
                            m_write_req  <= 1'b1;
                            m_write_addr <= sel_waddr;
                            m_write_data <= sel_wdata;
                        end
                    end
                end
                BUSY_RD, BUSY_WR: begin
                    if (finish) begin
                        state       <= IDLE;
                        m_read_req  <= 1'b0;
                        m_write_req <= 1'b0;
                        grant_valid <= 1'b0;
                        rr_ptr      <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter (default build, watchdog disabled) against a
// transaction-level round-robin model.
module tb_mem_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int GW = 2;

    logic             ACLK = 1'b0;
    logic             ARESETN = 1'b0;
    logic [NR-1:0]    req_read = '0;
    logic [NR-1:0]    req_write = '0;
    logic [NR*AW-1:0] req_read_addr = '0;
    logic [NR*AW-1:0] req_write_addr = '0;
    logic [NR*DW-1:0] req_write_data = '0;
    logic [NR-1:0]    req_read_done;
    logic [DW-1:0]    req_read_data;
    logic [NR-1:0]    req_write_done;
    logic             m_read_req;
    logic [AW-1:0]    m_read_addr;
    logic [DW-1:0]    m_read_data = '0;
    logic             m_read_done = 1'b0;
    logic             m_write_req;
    logic [AW-1:0]    m_write_addr;
    logic [DW-1:0]    m_write_data;
    logic             m_write_done = 1'b0;
    logic             grant_valid;
    logic [GW-1:0]    grant_idx;
    logic             timeout_err;

    mem_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_read(req_read), .req_write(req_write),
        .req_read_addr(req_read_addr), .req_write_addr(req_write_addr),
        .req_write_data(req_write_data),
        .req_read_done(req_read_done), .req_read_data(req_read_data),
        .req_write_done(req_write_done),
        .m_read_req(m_read_req), .m_read_addr(m_read_addr),
        .m_read_data(m_read_data), .m_read_done(m_read_done),
        .m_write_req(m_write_req), .m_write_addr(m_write_addr),
        .m_write_data(m_write_data), .m_write_done(m_write_done),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_err(timeout_err)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending work per requester plus the owner of the master port.
    bit          pend_rd[NR];
    bit          pend_wr[NR];
    logic [AW-1:0] raddr[NR];
    logic [AW-1:0] waddr[NR];
    logic [DW-1:0] wdata[NR];
    int          ptr;
    bit          busy;
    int          cur;
    bit          cur_rd;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    int          wait_left;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic drive_pins();
        for (int i = 0; i < NR; i++) begin
            req_read[i]                  = pend_rd[i];
            req_write[i]                 = pend_wr[i];
            req_read_addr[i*AW +: AW]    = raddr[i];
            req_write_addr[i*AW +: AW]   = waddr[i];
            req_write_data[i*DW +: DW]   = wdata[i];
        end
    endtask

    task automatic apply_stimulus(input int n, input int p_new);
        for (int c = 0; c < n; c++) begin
            logic          rdone;
            logic          wdone;
            logic [DW-1:0] rdata;
            bit            fin;
            logic [NR-1:0] exp_rdv;
            logic [NR-1:0] exp_wrv;
            @(negedge ACLK);
            check_output("grant_valid", 64'(grant_valid), 64'(busy));
            check_output("m_read_req", 64'(m_read_req), 64'(busy && cur_rd));
            check_output("m_write_req", 64'(m_write_req), 64'(busy && !cur_rd));
            if (busy) begin
                check_output("grant_idx", 64'(grant_idx), 64'(cur));
                if (cur_rd) begin
                    check_output("m_read_addr", 64'(m_read_addr), 64'(exp_addr));
                end else begin
                    check_output("m_write_addr", 64'(m_write_addr), 64'(exp_addr));
                    check_output("m_write_data", 64'(m_write_data), 64'(exp_data));
                end
            end
            // Addresses and data change every cycle; only the value at grant matters.
            for (int i = 0; i < NR; i++) begin
                raddr[i] = $urandom;
                waddr[i] = $urandom;
                wdata[i] = $urandom;
                if (!pend_rd[i] && !pend_wr[i] && ($urandom_range(99) < p_new)) begin
                    case ($urandom_range(2))
                        0: pend_rd[i] = 1'b1;
                        1: pend_wr[i] = 1'b1;
                        default: begin pend_rd[i] = 1'b1; pend_wr[i] = 1'b1; end
                    endcase
                end
            end
            rdone = 1'b0;
            wdone = 1'b0;
            rdata = $urandom;
            fin   = 1'b0;
            if (busy && wait_left == 0) begin
                fin = 1'b1;
                if (cur_rd) rdone = 1'b1; else wdone = 1'b1;
            end else begin
                if (busy) wait_left--;
                if ($urandom_range(3) == 0) begin
                    if (!busy) begin
                        rdone = 1'($urandom_range(1));
                        wdone = !rdone;
                    end else if (cur_rd) begin
                        wdone = 1'b1;
                    end else begin
                        rdone = 1'b1;
                    end
                end
            end
            m_read_done  = rdone;
            m_write_done = wdone;
            m_read_data  = rdata;
            drive_pins();
            #1;
            exp_rdv = (fin && cur_rd)  ? NR'(1) << cur : '0;
            exp_wrv = (fin && !cur_rd) ? NR'(1) << cur : '0;
            check_output("req_read_done", 64'(req_read_done), 64'(exp_rdv));
            check_output("req_write_done", 64'(req_write_done), 64'(exp_wrv));
            check_output("timeout_err", 64'(timeout_err), 64'(0));
            if (fin && cur_rd)
                check_output("req_read_data", 64'(req_read_data), 64'(rdata));
            if (fin) begin
                busy = 1'b0;
                ptr  = (cur + 1) % NR;
                if (cur_rd) pend_rd[cur] = 1'b0; else pend_wr[cur] = 1'b0;
                drive_pins();
            end else if (!busy) begin
                for (int k = 0; k < NR; k++) begin
                    int w;
                    w = (ptr + k) % NR;
                    if (!busy && (pend_rd[w] || pend_wr[w])) begin
                        busy      = 1'b1;
                        cur       = w;
                        cur_rd    = pend_rd[w];
                        exp_addr  = pend_rd[w] ? raddr[w] : waddr[w];
                        exp_data  = wdata[w];
                        wait_left = $urandom_range(4);
                    end
                end
            end
        end
    endtask

    initial begin
        bit got_write;
        for (int i = 0; i < NR; i++) begin
            pend_rd[i] = 1'b0; pend_wr[i] = 1'b0;
            raddr[i] = '0; waddr[i] = '0; wdata[i] = '0;
        end
        ptr = 0; busy = 1'b0; cur = 0; cur_rd = 1'b0;
        exp_addr = '0; exp_data = '0; wait_left = 0;

        repeat (2) @(negedge ACLK);
        check_output("rst_grant_valid", 64'(grant_valid), 64'(0));
        check_output("rst_grant_idx", 64'(grant_idx), 64'(0));
        check_output("rst_m_read_req", 64'(m_read_req), 64'(0));
        check_output("rst_m_write_req", 64'(m_write_req), 64'(0));
        check_output("rst_m_read_addr", 64'(m_read_addr), 64'(0));
        check_output("rst_m_write_addr", 64'(m_write_addr), 64'(0));
        check_output("rst_m_write_data", 64'(m_write_data), 64'(0));
        check_output("rst_read_done", 64'(req_read_done), 64'(0));
        check_output("rst_write_done", 64'(req_write_done), 64'(0));
        check_output("rst_timeout_err", 64'(timeout_err), 64'(0));
        ARESETN = 1'b1;

        apply_stimulus(300, 30);
        // Everyone reading and re-requesting immediately: strict rotation.
        for (int i = 0; i < NR; i++) pend_rd[i] = 1'b1;
        apply_stimulus(80, 100);
        apply_stimulus(200, 50);

        // Reset while a write owns the port.
        got_write = 1'b0;
        for (int t = 0; t < 400 && !got_write; t++) begin
            apply_stimulus(1, 50);
            if (busy && !cur_rd && wait_left >= 1) got_write = 1'b1;
        end
        check_output("found_write_grant", 64'(got_write), 64'(1));
        if (got_write) begin
            @(negedge ACLK);
            m_read_done  = 1'b0;
            m_write_done = 1'b0;
            check_output("pre_rst_m_write_req", 64'(m_write_req), 64'(1));
            #2 ARESETN = 1'b0;
            #1;
            check_output("midrst_m_write_req", 64'(m_write_req), 64'(0));
            check_output("midrst_grant_valid", 64'(grant_valid), 64'(0));
            check_output("midrst_write_done", 64'(req_write_done), 64'(0));
        end
        for (int i = 0; i < NR; i++) begin
            pend_rd[i] = 1'b0;
            pend_wr[i] = 1'b0;
        end
        busy = 1'b0;
        ptr  = 0;
        drive_pins();
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < NR; i++) pend_rd[i] = 1'b1;
        apply_stimulus(150, 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter sharing one AXI master read/write request interface between NUM_REQ CPU sequencers.
- Each sequencer issues level-held read_req/write_req with address and data, then waits for a done pulse.
- The arbiter grants one requester at a time and carries one transaction at a time to the master.
- It registers the address and data at grant, then routes done and read data back to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (>=2); GW = $clog2(NUM_REQ)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous active-low
- req_read  in  NUM_REQ  per-requester read request, held until its done
- req_write  in  NUM_REQ  per-requester write request, held until its done
- req_read_addr  in  NUM_REQ*ADDR_WIDTH  packed; slice i = requester i
- req_write_addr  in  NUM_REQ*ADDR_WIDTH  packed write addresses
- req_write_data  in  NUM_REQ*DATA_WIDTH  packed write data
- req_read_done  out  NUM_REQ  one-hot done pulse to the granted reader
- req_read_data  out  DATA_WIDTH  read data broadcast to all; valid only with req_read_done
- req_write_done  out  NUM_REQ  one-hot done pulse to the granted writer
- m_read_req  out  1  to AXI master: read request
- m_read_addr  out  ADDR_WIDTH  read address
- m_read_data  in  DATA_WIDTH  read data
- m_read_done  in  1  read transaction complete, 1-cycle pulse
- m_write_req  out  1  write request
- m_write_addr  out  ADDR_WIDTH  write address
- m_write_data  out  DATA_WIDTH  write data
- m_write_done  in  1  write transaction complete, 1-cycle pulse
- grant_valid  out  1  high while a transaction is owned
- grant_idx  out  GW  index of the owner
- timeout_err  out  1  1-cycle pulse on watchdog abort (tied 0 without the macro)

Behaviour:
- Reset (async, ARESETN low): state=IDLE, rr_ptr=0, grant_idx=0, grant_valid=0, m_read_req=0, m_write_req=0, m_*_addr=0, m_write_data=0, all done outputs 0, timeout_err=0.
- Reset mid-transaction drops m_*_req immediately. No done is issued for the aborted transaction.
- States: IDLE, BUSY_RD, BUSY_WR.
- IDLE:
  - Candidate i = req_read[i] | req_write[i].
  - Search order: rr_ptr, rr_ptr+1, … modulo NUM_REQ. The first candidate wins.
  - On the edge, latch grant_idx and grant_valid=1.
  - If the winner's req_read=1 (read has priority when a requester asserts both): go to BUSY_RD, m_read_req<=1, m_read_addr<=that requester's addr slice.
  - Otherwise: go to BUSY_WR, m_write_req<=1, m_write_addr and m_write_data<=that requester's slices.
  - No candidate: stay in IDLE.
- BUSY_RD/BUSY_WR:
  - m_*_req is held high and addr/data are held stable regardless of requester inputs. A requester deasserting mid-grant does not abort the transaction.
  - req_read_done[grant_idx] = m_read_done in BUSY_RD; req_read_data = m_read_data (combinational, same cycle).
  - req_write_done[grant_idx] = m_write_done in BUSY_WR.
  - On the done edge: clear m_*_req, grant_valid<=0, rr_ptr<=(grant_idx+1) mod NUM_REQ, go to IDLE.
  - m_read_done in BUSY_WR or m_write_done in BUSY_RD is ignored. m_*_done in IDLE is ignored.
- Latency:
  - Request visible at edge k (IDLE) -> m_*_req high in cycle k+1.
  - Done in cycle m -> requester done in cycle m.
  - There is at least one IDLE bubble cycle between transactions.
- Fairness: a requester that keeps its request asserted after done is served again only after every other pending requester has been served once.
- Done outputs are never asserted to a non-granted index.

Optional Feature:
- ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without m_*_done: pulse timeout_err for 1 cycle.
  - In that same cycle, pulse the granted requester's done with req_read_data=0 (for reads).
  - Drop m_*_req, advance rr_ptr and return to IDLE.
  - Done arriving in the same cycle as expiry counts as a normal completion, with no error.
- Undefined: no counter; timeout_err is tied 0; the grant is held indefinitely.

Test Plan:
- Single read: req_read[2]=1, addr 0x40; done after 3 cycles with m_read_data=0xA5A5_0001 -> m_read_addr=0x40; req_read_done=4'b0100 with data 0xA5A5_0001; rr_ptr=3.
- Contention: req_read=4'b1111 held continuously, done 2 cycles after each grant -> grant order 0,1,2,3,0; each done is one-hot to the matching index.
- Same requester both: req_read[1]=req_write[1]=1, write data 0x1234 -> read served first; after the read done and with req_read[1] dropped, a write to the write addr with data 0x1234 and req_write_done=4'b0010.
- Stability: requester 0 changes addr 0x10->0x20 mid-grant -> m_read_addr stays 0x10 until done.
- Async reset: ARESETN low while in BUSY_WR -> m_write_req=0 immediately; grant_valid=0; after release, arbitration restarts from index 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no m_read_done -> timeout_err pulses 8 cycles after grant; requester gets done with data 0; the next requester is granted.
